// File: rtl/tiger_memstage_pkg.sv
// Shared definitions for the Tiger memory-access stage.
// Control-word bit positions (CONTROL_*), control word width, and the
// MA stage load-tracking state encoding.
package tiger_memstage_pkg;

    localparam int CONTROL_WIDTH    = 8;

    localparam int CONTROL_MEMREAD  = 0;
    localparam int CONTROL_MEMWRITE = 1;
    localparam int CONTROL_MEM8     = 2;
    localparam int CONTROL_MEM16    = 3;
    localparam int CONTROL_MEML     = 4;
    localparam int CONTROL_MEMR     = 5;
    localparam int CONTROL_ZEROFILL = 6;
    localparam int CONTROL_REGWRITE = 7;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_WAIT  = 2'd1,
        MA_HELD  = 2'd2,
        MA_DRAIN = 2'd3
    } ma_state_t;

endpackage

// File: rtl/tiger_load_align.sv
// Combinational load-data alignment for the MA stage (little-endian).
// Ports:
//   d        raw 32-bit word returned by data memory
//   rt       current rt value, merged into LWL/LWR results
//   a        byte address bits [1:0]
//   mem8     byte load;  mem16 halfword load (a[0] ignored)
//   meml     LWL merge;  memr  LWR merge
//   zerofill zero-extend sub-word loads instead of sign-extending
//   aligned  value to be written back
module tiger_load_align (
    input  logic [31:0] d,
    input  logic [31:0] rt,
    input  logic [1:0]  a,
    input  logic        mem8,
    input  logic        mem16,
    input  logic        meml,
    input  logic        memr,
    input  logic        zerofill,
    output logic [31:0] aligned
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel    = d[{a, 3'b000} +: 8];
        hsel    = d[{a[1], 4'b0000} +: 16];
        aligned = d;
        if (mem8) begin
            aligned = {{24{bsel[7] & ~zerofill}}, bsel};
        end else if (mem16) begin
            aligned = {{16{hsel[15] & ~zerofill}}, hsel};
        end else if (meml) begin
            case (a)
                2'd0:    aligned = {d[7:0],  rt[23:0]};
                2'd1:    aligned = {d[15:0], rt[15:0]};
                2'd2:    aligned = {d[23:0], rt[7:0]};
                default: aligned = d;
            endcase
        end else if (memr) begin
            case (a)
                2'd0:    aligned = d;
                2'd1:    aligned = {rt[31:24], d[31:8]};
                2'd2:    aligned = {rt[31:16], d[31:16]};
                default: aligned = {rt[31:8],  d[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/tiger_memstage.sv
// Tiger MIPS memory-access (MA) stage.
// Aligns returned load data, requests a pipeline stall while a load waits
// for its read return, and registers the result into the WB registers.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   stall, clear      global stall (WB holds) and flush (WB zeroed)
//   instrMA, controlMA, executeoutMA, bottomaddressMA   MA pipeline registers
//   memreaddata, memreaddatavalid   data-memory read return (one pulse per read)
//   instrWB, controlWB, executeoutWB   WB pipeline registers
//   stallRq           combinational stall request
module tiger_memstage
    import tiger_memstage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     clear,
    input  logic [31:0]              instrMA,
    input  logic [CONTROL_WIDTH-1:0] controlMA,
    input  logic [31:0]              executeoutMA,
    input  logic [1:0]               bottomaddressMA,
    input  logic [31:0]              memreaddata,
    input  logic                     memreaddatavalid,
    output logic [31:0]              instrWB,
    output logic [CONTROL_WIDTH-1:0] controlWB,
    output logic [31:0]              executeoutWB,
    output logic                     stallRq
);

    ma_state_t   state, state_n;
    logic [31:0] holdreg;
    logic [31:0] d_sel;
    logic [31:0] aligned;
    logic        capture;
    logic        load;

    assign load = controlMA[CONTROL_MEMREAD];

    tiger_load_align u_align (
        .d        (d_sel),
        .rt       (executeoutMA),
        .a        (bottomaddressMA),
        .mem8     (controlMA[CONTROL_MEM8]),
        .mem16    (controlMA[CONTROL_MEM16]),
        .meml     (controlMA[CONTROL_MEML]),
        .memr     (controlMA[CONTROL_MEMR]),
        .zerofill (controlMA[CONTROL_ZEROFILL]),
        .aligned  (aligned)
    );

    always_comb begin
        state_n = state;
        stallRq = 1'b0;
        capture = 1'b0;
        d_sel   = memreaddata;
        case (state)
            MA_IDLE: begin
                if (load) begin
                    if (memreaddatavalid) begin
                        if (!clear && stall) begin
                            capture = 1'b1;
                            state_n = MA_HELD;
                        end
                    end else begin
                        // A flushed load still has a read in flight; its
                        // return must be dropped, hence DRAIN.
                        stallRq = 1'b1;
                        state_n = clear ? MA_DRAIN : MA_WAIT;
                    end
                end
            end
            MA_WAIT: begin
                if (memreaddatavalid) begin
                    if (clear) begin
                        state_n = MA_IDLE;
                    end else if (stall) begin
                        capture = 1'b1;
                        state_n = MA_HELD;
                    end else begin
                        state_n = MA_IDLE;
                    end
                end else begin
                    stallRq = 1'b1;
                    state_n = clear ? MA_DRAIN : MA_WAIT;
                end
            end
            MA_HELD: begin
                d_sel = holdreg;
                if (clear || !stall) begin
                    state_n = MA_IDLE;
                end
            end
            MA_DRAIN: begin
                // The next return belongs to the flushed load; a load now in
                // MA must keep waiting for the return after it.
                stallRq = load;
                if (memreaddatavalid) begin
                    state_n = MA_IDLE;
                end
            end
            default: state_n = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= MA_IDLE;
            holdreg      <= '0;
            instrWB      <= '0;
            controlWB    <= '0;
            executeoutWB <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                holdreg <= memreaddata;
            end
            if (clear) begin
                instrWB      <= '0;
                controlWB    <= '0;
                executeoutWB <= '0;
            end else if (!stall && !stallRq) begin
                instrWB      <= instrMA;
                controlWB    <= controlMA;
                executeoutWB <= load ? aligned : executeoutMA;
            end
        end
    end

endmodule

// File: tb/tb_tiger_memstage.sv
// Self-checking bench for tiger_memstage: table of single-cycle loads and
// pass-throughs, plus hand-written multi-cycle sequences (wait, hold,
// flush/drain, asynchronous reset).
module tb_tiger_memstage;
    import tiger_memstage_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset, stall, clear;
    logic [31:0]              instrMA, executeoutMA, memreaddata;
    logic [CONTROL_WIDTH-1:0] controlMA;
    logic [1:0]               bottomaddressMA;
    logic                     memreaddatavalid;
    logic [31:0]              instrWB, executeoutWB;
    logic [CONTROL_WIDTH-1:0] controlWB;
    logic                     stallRq;

    tiger_memstage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .clear            (clear),
        .instrMA          (instrMA),
        .controlMA        (controlMA),
        .executeoutMA     (executeoutMA),
        .bottomaddressMA  (bottomaddressMA),
        .memreaddata      (memreaddata),
        .memreaddatavalid (memreaddatavalid),
        .instrWB          (instrWB),
        .controlWB        (controlWB),
        .executeoutWB     (executeoutWB),
        .stallRq          (stallRq)
    );

    always #5 clk = ~clk;

    localparam logic [CONTROL_WIDTH-1:0] B_RD = CONTROL_WIDTH'(1) << CONTROL_MEMREAD;
    localparam logic [CONTROL_WIDTH-1:0] B_RW = CONTROL_WIDTH'(1) << CONTROL_REGWRITE;
    localparam logic [CONTROL_WIDTH-1:0] B_M8 = CONTROL_WIDTH'(1) << CONTROL_MEM8;
    localparam logic [CONTROL_WIDTH-1:0] B_M16 = CONTROL_WIDTH'(1) << CONTROL_MEM16;
    localparam logic [CONTROL_WIDTH-1:0] B_ML = CONTROL_WIDTH'(1) << CONTROL_MEML;
    localparam logic [CONTROL_WIDTH-1:0] B_MR = CONTROL_WIDTH'(1) << CONTROL_MEMR;
    localparam logic [CONTROL_WIDTH-1:0] B_ZF = CONTROL_WIDTH'(1) << CONTROL_ZEROFILL;

    localparam logic [CONTROL_WIDTH-1:0] C_LW  = B_RD | B_RW;
    localparam logic [CONTROL_WIDTH-1:0] C_LB  = C_LW | B_M8;
    localparam logic [CONTROL_WIDTH-1:0] C_LBU = C_LB | B_ZF;
    localparam logic [CONTROL_WIDTH-1:0] C_LH  = C_LW | B_M16;
    localparam logic [CONTROL_WIDTH-1:0] C_LHU = C_LH | B_ZF;
    localparam logic [CONTROL_WIDTH-1:0] C_LWL = C_LW | B_ML;
    localparam logic [CONTROL_WIDTH-1:0] C_LWR = C_LW | B_MR;
    localparam logic [CONTROL_WIDTH-1:0] C_ALU = B_RW;

    typedef struct {
        logic [CONTROL_WIDTH-1:0] ctrl;
        logic [1:0]               a;
        logic [31:0]              d;
        logic [31:0]              rt;
        logic [31:0]              exp;
    } vec_t;

    vec_t vecs[17];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One pipeline cycle: drive return/stall/clear just after an edge,
    // check stallRq mid-cycle, then advance past the next rising edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic st,
                       input logic cl, input logic exp_rq, input string tag);
        memreaddatavalid = v;
        memreaddata      = d;
        stall            = st;
        clear            = cl;
        #3;
        chk({tag, " stallRq"}, {31'b0, stallRq}, {31'b0, exp_rq});
        @(posedge clk);
        #1;
        memreaddatavalid = 1'b0;
        clear            = 1'b0;
        stall            = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{C_LB,  2'd3, 32'h80FF_1234, 32'h0,         32'hFFFF_FF80};
        vecs[1]  = '{C_LBU, 2'd1, 32'h80FF_1234, 32'h0,         32'h0000_0012};
        vecs[2]  = '{C_LB,  2'd2, 32'h80FF_1234, 32'h0,         32'hFFFF_FFFF};
        vecs[3]  = '{C_LBU, 2'd2, 32'h80FF_1234, 32'h0,         32'h0000_00FF};
        vecs[4]  = '{C_LH,  2'd0, 32'h80FF_1234, 32'h0,         32'h0000_1234};
        vecs[5]  = '{C_LH,  2'd2, 32'h80FF_1234, 32'h0,         32'hFFFF_80FF};
        vecs[6]  = '{C_LHU, 2'd3, 32'h80FF_1234, 32'h0,         32'h0000_80FF};
        vecs[7]  = '{C_LW,  2'd2, 32'h80FF_1234, 32'h0,         32'h80FF_1234};
        vecs[8]  = '{C_LWL, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'h44BB_CCDD};
        vecs[9]  = '{C_LWL, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'h3344_CCDD};
        vecs[10] = '{C_LWL, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'h2233_44DD};
        vecs[11] = '{C_LWL, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_3344};
        vecs[12] = '{C_LWR, 2'd0, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_3344};
        vecs[13] = '{C_LWR, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAA11_2233};
        vecs[14] = '{C_LWR, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_1122};
        vecs[15] = '{C_LWR, 2'd3, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CC11};
        // stray valid with no load in MA is ignored
        vecs[16] = '{C_ALU, 2'd1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        reset            = 1'b1;
        stall            = 1'b0;
        clear            = 1'b0;
        instrMA          = 32'h0;
        controlMA        = '0;
        executeoutMA     = 32'h0;
        bottomaddressMA  = 2'd0;
        memreaddata      = 32'h0;
        memreaddatavalid = 1'b0;
        #1;
        chk("reset executeoutWB", executeoutWB, 32'h0);
        chk("reset instrWB", instrWB, 32'h0);
        chk("reset controlWB", {24'b0, controlWB}, 32'h0);
        chk("reset stallRq", {31'b0, stallRq}, 32'h0);
        #11;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: latency-1 loads and pass-throughs, no stall expected.
        for (int i = 0; i < 17; i++) begin
            controlMA       = vecs[i].ctrl;
            bottomaddressMA = vecs[i].a;
            executeoutMA    = vecs[i].rt;
            instrMA         = 32'h1000_0000 + 32'(i);
            cyc(1'b1, vecs[i].d, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d executeoutWB", i), executeoutWB, vecs[i].exp);
            chk($sformatf("vec%0d controlWB", i), {24'b0, controlWB}, {24'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d instrWB", i), instrWB, 32'h1000_0000 + 32'(i));
        end

        // LHU a=2, valid on the third MA cycle: two stall cycles.
        controlMA = C_LHU; bottomaddressMA = 2'd2; executeoutMA = 32'h0; instrMA = 32'h2000_0001;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "lhu c1");
        chk("lhu held WB", executeoutWB, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "lhu c2");
        chk("lhu held WB2", executeoutWB, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h8001_5555, 1'b0, 1'b0, 1'b0, "lhu c3");
        chk("lhu executeoutWB", executeoutWB, 32'h0000_8001);
        chk("lhu instrWB", instrWB, 32'h2000_0001);

        // LW: WAIT, then valid under stall -> HELD until stall falls.
        controlMA = C_LW; bottomaddressMA = 2'd0; instrMA = 32'h2000_0002;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "held c1");
        cyc(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, "held c2");
        cyc(1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0, "held c3");
        chk("held WB hold", executeoutWB, 32'h0000_8001);
        cyc(1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0, "held c4");
        chk("held WB hold2", executeoutWB, 32'h0000_8001);
        cyc(1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0, "held c5");
        chk("held executeoutWB", executeoutWB, 32'hCAFE_F00D);

        // Flush mid-WAIT, next LW enters before the stale return.
        instrMA = 32'h2000_0003;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "drain c1");
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "drain c2");
        chk("drain clear WB", executeoutWB, 32'h0);
        instrMA = 32'h2000_0004;
        cyc(1'b1, 32'hBADB_AD00, 1'b0, 1'b0, 1'b1, "drain c3");
        chk("drain stale dropped", executeoutWB, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "drain c4");
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "drain c5");
        chk("drain executeoutWB", executeoutWB, 32'h1234_5678);
        chk("drain instrWB", instrWB, 32'h2000_0004);

        // Asynchronous reset between edges while in WAIT.
        instrMA = 32'h2000_0005;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "rst c1");
        #2;
        reset = 1'b1;
        #1;
        chk("rst executeoutWB", executeoutWB, 32'h0);
        chk("rst instrWB", instrWB, 32'h0);
        chk("rst controlWB", {24'b0, controlWB}, 32'h0);
        chk("rst stallRq load", {31'b0, stallRq}, 32'h1);
        controlMA = C_ALU;
        executeoutMA = 32'h5A5A_5A5A;
        #1;
        chk("rst stallRq noload", {31'b0, stallRq}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst post WB", executeoutWB, 32'h5A5A_5A5A);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "rst idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tiger_memstage.md
# tiger_memstage

Memory-access (MA) stage of the hybrid pipelined Tiger MIPS core. Sits directly downstream of the execute stage and directly upstream of writeback. It takes the execute stage's MA pipeline registers and the data-memory read return. It aligns and sign/zero-extends load data (byte, halfword, word, LWL/LWR merge), holds the pipeline with a stall request while a load is outstanding, and registers the result into the WB pipeline registers.

## Interface
- No parameters; widths from `tiger_defines.v` (`CONTROL_WIDTH`).
- clk  in  1  pipeline clock.
- reset  in  1  **asynchronous, active-high** reset.
- stall  in  1  global pipeline stall; WB registers hold.
- clear  in  1  flush; WB registers load zero.
- instrMA  in  32  instruction in MA.
- controlMA  in  `CONTROL_WIDTH`  control word in MA.
- executeoutMA  in  32  execute result; the rt value for LWL/LWR.
- bottomaddressMA  in  2  memaddress[1:0], registered by execute alongside the other MA registers.
- memreaddata  in  32  data-memory read return.
- memreaddatavalid  in  1  one-cycle pulse; one pulse per issued read, in issue order.
- instrWB  out  32  registered instruction to WB.
- controlWB  out  `CONTROL_WIDTH`  registered control to WB.
- executeoutWB  out  32  registered result: the aligned load value for loads, executeoutMA otherwise.
- stallRq  out  1  request global stall (combinational).

## Operation
- Load in MA = controlMA[`CONTROL_MEMREAD`]. The read request was issued by execute in the cycle before the load entered MA. Read latency is ≥1 cycle and variable.
- Data is little-endian: byte k occupies bits 8k+7:8k; a = bottomaddressMA.
- MEM8: byte a. MEM16: halfword a[1] (a[0] ignored).
  - Zero-extend when `CONTROL_ZEROFILL` is set; otherwise sign-extend.
- Word load with neither MEM8 nor MEM16: data passes through unchanged.
- MEML (LWL), with rt = executeoutMA:
  - a=0 → {d[7:0], rt[23:0]}
  - a=1 → {d[15:0], rt[15:0]}
  - a=2 → {d[23:0], rt[7:0]}
  - a=3 → d
- MEMR (LWR):
  - a=0 → d
  - a=1 → {rt[31:24], d[31:8]}
  - a=2 → {rt[31:16], d[31:16]}
  - a=3 → {rt[31:8], d[31:24]}
- Non-loads pass executeoutMA unchanged.
- FSM states: IDLE, WAIT, HELD, DRAIN. Encoding is two bits.
  - IDLE, load, valid=1:
    - stall=0 → result to WB.
    - stall=1 → capture d into holdreg, go to HELD.
  - IDLE, load, valid=0 → stallRq=1, go to WAIT.
  - WAIT, valid=0 → stallRq=1.
  - WAIT, valid=1 and stall=0 (stallRq dropping) → result to WB, go to IDLE.
  - WAIT, valid=1 and stall=1 → capture into holdreg, go to HELD.
  - HELD: stallRq=0; the result uses holdreg. When stall=0 → WB loads it, go to IDLE.
  - clear in WAIT (valid=0) → go to DRAIN; the return is discarded.
  - clear in HELD → go to IDLE; holdreg is discarded.
  - DRAIN: stallRq=1 if a load is in MA. On valid → go to IDLE, data dropped.
  - memreaddatavalid in IDLE with no load in MA: ignored.
- clear has priority over stall for the WB registers. reset has priority over everything.

## Timing
- Reset (async): all outputs 0, state IDLE, holdreg 0.
  - stallRq is 0 unless a load sits in MA without valid data.
- Load latency 1 (valid in first MA cycle): no stall; WB updated at the next edge.
- Latency N>1: stallRq high for N−1 cycles; WB updated at the edge of the valid cycle.
- stallRq is combinational from state, controlMA and memreaddatavalid. It drops in the same cycle valid arrives.
- Reset mid-WAIT: the outstanding return is not tracked. The memory system is reset together with the core.
- WB registers update only when stall=0 and stallRq=0.
  - Exception: clear zeroes them regardless.

## Structure
- `tiger_defines.v`:
  - existing CONTROL_* bit fields.
  - add MA_IDLE / MA_WAIT / MA_HELD / MA_DRAIN state constants.
- Sub-module `tiger_load_align`: combinational. Inputs d, rt, a, mem8, mem16, meml, memr, zerofill; output aligned word.
- FSM, holdreg and the WB registers stay in tiger_memstage.

## Test plan
- LB, a=3, d=0x80FF_1234, valid same cycle → executeoutWB=0xFFFF_FF80 next edge; stallRq never high.
- LHU, a=2, d=0x8001_5555, valid after 3 cycles → stallRq high 2 cycles; executeoutWB=0x0000_8001.
- LWL a=1, rt=0xAABB_CCDD, d=0x1122_3344 → 0x3344_CCDD. LWR a=1 with the same operands → 0xAA11_2233.
- LW in WAIT, valid arrives with stall=1 for 2 more cycles → HELD; holdreg kept; WB=d when stall falls; stallRq=0 throughout HELD.
- clear during WAIT, then an LW enters MA before the stale valid → stale data dropped (DRAIN), stallRq held; the second valid delivers the new LW data.
- reset asserted mid-WAIT, asynchronously between edges → outputs 0 immediately, state IDLE, stallRq=0 once no load is in MA.
